seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-seg display.

---
 rtl/seven_seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Holds one display code per digit, adds anti-ghost blanking, leading-zero blanking and a frame pulse.
module seven_seg_scan_ctrl #(
    parameter int unsigned NDIGITS      = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned GHOST_CYCLES = 1000,
    localparam int unsigned AW          = $clog2(NDIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               lzb_en,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [6:0]         wr_data,
    output logic [6:0]         seg_data,
    output logic [NDIGITS-1:0] an_n,
    output logic [AW-1:0]      digit_idx,
    output logic               frame_done
);

    localparam int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0]  CODE_OFF = 7'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic [6:0]    regfile [NDIGITS];
    logic [AW-1:0] idx_nxt;
    logic          cnt_last;
    logic          ghost_done;
    logic          wr_ok;

    always_comb begin
        idx_nxt    = (digit_idx == AW'(NDIGITS - 1)) ? '0 : digit_idx + AW'(1);
        cnt_last   = (div_cnt == CW'(TICK_DIV - 1));
        ghost_done = ((32'(div_cnt) + 32'd1) >= GHOST_CYCLES);
        wr_ok      = wr_en && (32'(wr_addr) < NDIGITS);
    end

    // Display code for digit i; blanked when it and every more-significant digit hold 7'h00.
    function automatic logic [6:0] eff_code(input logic [AW-1:0] i);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < int'(NDIGITS); j++) begin
            if ((j >= int'(i)) && (regfile[j] != 7'h00)) upper_zero = 1'b0;
        end
        if (lzb_en && (i != '0) && upper_zero) return CODE_OFF;
        return regfile[i];
    endfunction

    function automatic logic [NDIGITS-1:0] digit_on(input logic [AW-1:0] i);
        return ~(NDIGITS'(1) << i);
    endfunction

    // Digit register file; a write never alters the code already latched for the current slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NDIGITS); k++) regfile[k] <= CODE_OFF;
        end else if (wr_ok) begin
            regfile[wr_addr] <= wr_data;
        end
    end

    // Scan FSM: each slot is GHOST_CYCLES dark cycles followed by the lit phase.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state      <= IDLE;
            div_cnt    <= '0;
            digit_idx  <= '0;
            seg_data   <= CODE_OFF;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt    <= '0;
                    digit_idx  <= '0;
                    seg_data   <= eff_code('0);
                    frame_done <= 1'b0;
                    if (GHOST_CYCLES == 0) begin
                        state <= SHOW;
                        an_n  <= digit_on('0);
                    end else begin
                        state <= BLANK;
                        an_n  <= '1;
                    end
                end
                BLANK, SHOW: begin
                    if (cnt_last) begin
                        div_cnt    <= '0;
                        digit_idx  <= idx_nxt;
                        seg_data   <= eff_code(idx_nxt);
                        frame_done <= 1'b0;
                        if (GHOST_CYCLES == 0) begin
                            state <= SHOW;
                            an_n  <= digit_on(idx_nxt);
                        end else begin
                            state <= BLANK;
                            an_n  <= '1;
                        end
                    end else begin
                        div_cnt    <= div_cnt + CW'(1);
                        frame_done <= (digit_idx == AW'(NDIGITS - 1)) &&
                                      (div_cnt == CW'(TICK_DIV - 2));
                        if (ghost_done) begin
                            state <= SHOW;
                            an_n  <= digit_on(digit_idx);
                        end else begin
                            state <= BLANK;
                            an_n  <= '1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    div_cnt    <= '0;
                    digit_idx  <= '0;
                    seg_data   <= CODE_OFF;
                    an_n       <= '1;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random traffic against a time-based display model.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned TD = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst, enable, lzb_en, wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [6:0]    seg_data;
    logic [N-1:0]  an_n;
    logic [AW-1:0] digit_idx;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    seven_seg_scan_ctrl #(.NDIGITS(N), .TICK_DIV(TD), .GHOST_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .enable(enable), .lzb_en(lzb_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .seg_data(seg_data), .an_n(an_n), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: the display is a function of cycles elapsed since the scan started.
    logic [6:0] m_reg [N];
    logic [6:0] m_seg;
    bit         m_run;
    int         m_t;

    function automatic logic [6:0] m_eff(input int i);
        bit zeros = 1;
        for (int j = i; j < int'(N); j++) if (m_reg[j] != 7'h00) zeros = 0;
        if (lzb_en && i > 0 && zeros) return 7'h40;
        return m_reg[i];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) m_reg[k] = 7'h40;
            m_run = 0;
            m_t   = 0;
            m_seg = 7'h40;
        end else begin
            if (!enable) begin
                m_run = 0;
                m_t   = 0;
                m_seg = 7'h40;
            end else if (!m_run) begin
                m_run = 1;
                m_t   = 0;
                m_seg = m_eff(0);
            end else begin
                m_t = m_t + 1;
                if (m_t % TD == 0) m_seg = m_eff((m_t / TD) % N);
            end
            if (wr_en && int'(wr_addr) < int'(N)) m_reg[wr_addr] = wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        int pos, dig;
        logic [N-1:0] e_an;
        pos = m_t % TD;
        dig = (m_t / TD) % N;
        if (!m_run) begin
            check("an_n",       32'(an_n),       32'(4'hF));
            check("seg_data",   32'(seg_data),   32'(7'h40));
            check("digit_idx",  32'(digit_idx),  0);
            check("frame_done", 32'(frame_done), 0);
        end else begin
            e_an = (pos < int'(G)) ? 4'hF : ~(4'b0001 << dig);
            check("an_n",       32'(an_n),       32'(e_an));
            check("seg_data",   32'(seg_data),   32'(m_seg));
            check("digit_idx",  32'(digit_idx),  32'(dig));
            check("frame_done", 32'(frame_done), 32'((dig == int'(N) - 1) && (pos == int'(TD) - 1)));
        end
    endtask

    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            check_outputs();
            wr_en = 1'b0;
        end
    endtask

    task automatic wr(input int a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; lzb_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cyc(2);
        rst = 1'b0;
        cyc(100);

        // Basic scan: codes 1..4 on digits 0..3.
        for (int i = 0; i < 4; i++) wr(i, 7'(i + 1));
        enable = 1'b1;
        cyc(80);

        // Leading-zero blanking on, then off, with 00,05,00,00.
        lzb_en = 1'b1;
        wr(0, 7'h00); wr(1, 7'h05); wr(2, 7'h00); wr(3, 7'h00);
        cyc(70);
        lzb_en = 1'b0;
        cyc(40);

        // Mid-slot write to digit 1 while it is lit.
        while (!(an_n == 4'b1101)) cyc(1);
        wr(1, 7'h2A);
        cyc(40);

        // Disable during digit 2 lit phase, re-enable, then reset mid-scan.
        while (!(an_n == 4'b1011)) cyc(1);
        enable = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(20);
        while (!(an_n == 4'b1011)) cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(40);

        // Random traffic.
        for (int r = 0; r < 3000; r++) begin
            if (enable) begin
                if ($urandom_range(199) == 0) enable = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                enable = 1'b1;
            end
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(99) == 0) lzb_en = ~lzb_en;
            if ($urandom_range(5) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(N - 1));
                wr_data = ($urandom_range(1) == 0) ? 7'h00 : 7'($urandom);
            end
            cyc(1);
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
